printf_request_arbiter: RTL
===========================

Name: printf_request_arbiter

Overview:
- Synthesizable front-end that collects bare-metal printf requests from the RISC-V cores and serializes them into the system driver's single printf command/address flag pair.
- Each core posts the scratchpad address of its 128-byte print buffer.
- The block round-robin arbitrates, queues the requests, tags each one with the core ID, and holds a level command until the system thread acknowledges it.
- It sits directly upstream of the system driver's printf DVT-flag handling.

Parameters:
- NUM_CORES, 4, number of requesting cores; must be ≤ 4 because the core ID occupies addr[1:0].
- ADDR_WIDTH, 32, width of the buffer address.
- FIFO_DEPTH, 4, queued-request entries; power of two, ≥ 2.
- TIMEOUT_CYCLES, 65535, acknowledge timeout; used only with the optional feature.

Ports:
- clk  in  1  block clock
- rst  in  1  asynchronous active-high reset
- core_req_valid  in  NUM_CORES  per-core request valid
- core_req_addr  in  NUM_CORES*ADDR_WIDTH  per-core buffer address; core i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH]
- core_req_ready  out  NUM_CORES  per-core accept; a transfer occurs when valid and ready are both high
- printf_cmd  out  1  level command to the driver flag
- printf_addr  out  ADDR_WIDTH  tagged buffer address, stable while printf_cmd is high
- printf_ack  in  1  one-cycle pulse when the driver has finished printing
- busy  out  1  FIFO not empty or a command is outstanding
- timeout_err  out  1  sticky acknowledge-timeout error

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: all outputs are 0. FIFO is empty, round-robin pointer is 0, FSM is in IDLE.
- Arbitration:
  - The arbiter considers valid cores only while the FIFO is not full.
  - Exactly one core_req_ready bit is high per cycle: the first valid core at or after the rr pointer, in index order with wrap.
  - After each grant the rr pointer becomes (granted+1) mod NUM_CORES.
  - When the FIFO is full, all ready bits are 0.
  - No combinational path from valid to ready of another core is allowed beyond the arbiter itself.
- Tagging:
  - Stored entry = {core_req_addr[granted][ADDR_WIDTH-1:2], granted[1:0]}.
  - Buffers are 8-byte aligned, so address bits [1:0] are discarded.
- FIFO:
  - Synchronous, with simultaneous push and pop allowed.
  - Push at full cannot occur because ready is gated. Pop at empty cannot occur because it is FSM-gated.
  - Occupancy counter width is clog2(FIFO_DEPTH)+1. Read and write pointers wrap modulo FIFO_DEPTH.
- FSM states:
  - IDLE: if the FIFO is not empty, pop the head into the printf_addr register and go to ISSUE.
  - ISSUE: printf_cmd is 1 (registered, one cycle after the pop); go to WAIT.
  - WAIT: hold printf_cmd=1 and printf_addr unchanged. On printf_ack, go to GAP with printf_cmd=0 on the next cycle.
  - GAP: one mandatory cycle with printf_cmd low so the driver sees a fresh posedge; then return to IDLE.
  - Minimum spacing between command rising edges is 4 cycles.
- Ack handling:
  - printf_ack outside WAIT is ignored.
  - printf_ack in the same cycle as entry to WAIT is honoured.
- busy = (FIFO count != 0) or (FSM != IDLE).
- Reset mid-operation: all state is cleared asynchronously and any outstanding request is dropped; printf_cmd falls immediately.

Optional Feature:
- Macro: PRINTF_ARB_TIMEOUT_EN.
- With the macro defined:
  - A 32-bit counter clears on entry to WAIT and increments in WAIT.
  - When the count reaches TIMEOUT_CYCLES without an ack, the FSM goes to GAP (the request is dropped) and timeout_err is set.
  - timeout_err is cleared only by rst.
- Without the macro: no counter is built, timeout_err is tied to 0, and WAIT waits indefinitely.

Decomposition:
- Shared package printf_arb_pkg holds:
  - FSM state enum {IDLE, ISSUE, WAIT, GAP};
  - CORE_ID_W=2 constant;
  - entry typedef (addr upper bits plus core ID).
- One sub-module, printf_req_fifo: a parameterized synchronous FIFO with full/empty/count outputs.
- Arbiter and FSM stay in the top module.

Test Plan:
- Single request: core 2 posts addr 0x8000_1000 → printf_addr=0x8000_1002 and printf_cmd high 2 cycles after acceptance; ack → cmd low next cycle; busy=0 by the IDLE cycle.
- All four cores valid in the same cycle with addrs 0x100/0x200/0x300/0x400 → grants in order 0,1,2,3; issued addrs 0x100, 0x201, 0x302, 0x403.
- Fill: hold ack low with 6 requests (FIFO_DEPTH=4) → 1 request in WAIT plus 4 queued; all ready=0 until the first ack; no request is lost or duplicated.
- Back-to-back acks issued immediately → printf_cmd shows a low cycle between every command; rising edges are ≥4 cycles apart.
- Assert rst in WAIT with 2 requests queued → printf_cmd=0, busy=0, all ready=0 during reset; a post-reset request is served with core 0 priority.
- With PRINTF_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, no ack → timeout_err=1 after 16 WAIT cycles; the next queued request issues; timeout_err stays 1.

Source files
------------

// File: rtl/printf_arb_pkg.sv
// Shared types for the printf request arbiter: FSM states, core-ID width and
// the tagged FIFO entry layout.
package printf_arb_pkg;

    localparam int unsigned CORE_ID_W    = 2;
    localparam int unsigned ENTRY_ADDR_W = 32;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StGap
    } arb_state_e;

    // Buffers are 8-byte aligned, so the low address bits carry the core ID.
    typedef struct packed {
        logic [ENTRY_ADDR_W-1:CORE_ID_W] addr_hi;
        logic [CORE_ID_W-1:0]            core_id;
    } entry_t;

endpackage

// File: rtl/printf_req_fifo.sv
// Parameterized synchronous FIFO for tagged printf requests; DEPTH must be a
// power of two so the pointers wrap naturally.
module printf_req_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push_ok, pop_ok;

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            unique case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/printf_request_arbiter.sv
// Round-robin collector of per-core printf requests feeding the driver's single
// cmd/addr flag pair. Define PRINTF_ARB_TIMEOUT_EN to build the ack timeout.
module printf_request_arbiter
    import printf_arb_pkg::*;
#(
    parameter int unsigned NUM_CORES      = 4,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_CORES-1:0]            core_req_valid,
    input  logic [NUM_CORES*ADDR_WIDTH-1:0] core_req_addr,
    output logic [NUM_CORES-1:0]            core_req_ready,
    output logic                            printf_cmd,
    output logic [ADDR_WIDTH-1:0]           printf_addr,
    input  logic                            printf_ack,
    output logic                            busy,
    output logic                            timeout_err
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    // The entry layout is fixed by the package, so the address width must match it.
    if (NUM_CORES < 1 || NUM_CORES > 4 || ADDR_WIDTH != ENTRY_ADDR_W || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("printf_request_arbiter: unsupported parameter set");
    end

    arb_state_e             state_q, state_d;
    logic [CORE_ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic                   cmd_q, cmd_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;

    logic [NUM_CORES-1:0]   grant_oh;
    logic [CORE_ID_W-1:0]   grant_idx;
    logic                   grant_any;
    logic [ADDR_WIDTH-1:0]  grant_addr;
    logic                   push, pop;
    entry_t                 push_entry;
    logic [ADDR_WIDTH-1:0]  fifo_rdata;
    logic                   fifo_full, fifo_empty;
    logic [CNT_W-1:0]       fifo_count;
    logic                   tmo_hit;
    logic                   unused_addr_lsbs;

    // Lowest valid overall, then overridden by the lowest valid at/after rr.
    always_comb begin
        grant_idx = '0;
        grant_any = 1'b0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (core_req_valid[i]) begin
                grant_idx = CORE_ID_W'(i);
                grant_any = 1'b1;
            end
        end
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (core_req_valid[i] && (CORE_ID_W'(i) >= rr_ptr_q)) grant_idx = CORE_ID_W'(i);
        end
    end

    always_comb begin
        grant_oh   = '0;
        grant_addr = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            grant_oh[i] = grant_any && (CORE_ID_W'(i) == grant_idx);
            if (grant_oh[i]) grant_addr = core_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        end
    end

    assign core_req_ready     = (rst || fifo_full) ? '0 : grant_oh;
    assign push               = |core_req_ready;
    assign push_entry.addr_hi = grant_addr[ADDR_WIDTH-1:CORE_ID_W];
    assign push_entry.core_id = grant_idx;
    assign unused_addr_lsbs   = ^grant_addr[CORE_ID_W-1:0];

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (push) begin
            rr_ptr_d = (grant_idx == CORE_ID_W'(NUM_CORES - 1)) ? '0 : grant_idx + CORE_ID_W'(1);
        end
    end

    printf_req_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (push_entry),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = StIssue;
                end
            end
            StIssue: state_d = StWait;
            StWait:  if (printf_ack || tmo_hit) state_d = StGap;
            StGap:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
        cmd_d  = (state_d == StIssue) || (state_d == StWait);
        addr_d = pop ? fifo_rdata : addr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            rr_ptr_q <= '0;
            cmd_q    <= 1'b0;
            addr_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            cmd_q    <= cmd_d;
            addr_q   <= addr_d;
        end
    end

`ifdef PRINTF_ARB_TIMEOUT_EN
    logic [31:0] tmo_cnt_q, tmo_cnt_d;
    logic        tmo_err_q;

    assign tmo_hit   = (state_q == StWait) && (tmo_cnt_q == 32'(TIMEOUT_CYCLES - 1));
    // Held at zero outside WAIT, so it always restarts from zero on entry.
    assign tmo_cnt_d = (state_q == StWait) ? tmo_cnt_q + 32'd1 : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_q <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            if (tmo_hit && !printf_ack) tmo_err_q <= 1'b1;
        end
    end

    assign timeout_err = tmo_err_q;
`else
    assign tmo_hit     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign printf_cmd  = cmd_q;
    assign printf_addr = addr_q;
    assign busy        = (fifo_count != '0) || (state_q != StIdle);

endmodule
